// File: rtl/skolem_sweep_ctrl_if.sv
// Handshake and Skolem-bus bundle for skolem_sweep_ctrl.
// master: requester side (drives start, supplies the Skolem output x).
// slave : the sweep controller (drives the Skolem inputs and the result status).
interface skolem_sweep_ctrl_if #(
    parameter int W = 4
);
    logic             start;
    logic [2*W-1:0]   sk_in;
    logic [W-1:0]     sk_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2*W:0]     fail_cnt;
    logic [2*W:0]     vac_cnt;
    logic [2*W-1:0]   first_fail;

    modport master (
        output start, sk_out,
        input  sk_in, busy, done, pass, fail_cnt, vac_cnt, first_fail
    );

    modport slave (
        input  start, sk_out,
        output sk_in, busy, done, pass, fail_cnt, vac_cnt, first_fail
    );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sequencer/checker for a W-bit Skolem function of
// (x udiv s) >=s t. Sweeps every {t,s} vector, brute-forces feasibility
// over all candidates x, then checks the attached Skolem output.
// Optional macro STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module skolem_sweep_ctrl #(
    parameter int W      = 4,
    parameter int SK_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    skolem_sweep_ctrl_if.slave    sweep
);
    localparam int WT_W = $clog2(SK_LAT + 2);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t            r_state;
    logic [2*W-1:0]    r_v;
    logic [W-1:0]      r_c;
    logic [WT_W-1:0]   r_wcnt;
    logic              r_exists;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [2*W:0]      r_fail_cnt;
    logic [2*W:0]      r_vac_cnt;
    logic [2*W-1:0]    r_first_fail;

    logic [W-1:0]      w_s;
    logic [W-1:0]      w_t;
    logic              w_cand_ok;
    logic              w_sk_ok;
    logic              w_fail;
    logic              w_last;

    // (x udiv s) >=s t, with x udiv 0 defined as all ones
    function automatic logic constraint_ok(input logic [W-1:0] x,
                                           input logic [W-1:0] s,
                                           input logic [W-1:0] t);
        logic [W-1:0] q;
        q = (s == '0) ? '1 : x / s;
        return $signed(q) >= $signed(t);
    endfunction

    assign w_s       = r_v[W-1:0];
    assign w_t       = r_v[2*W-1:W];
    assign w_cand_ok = constraint_ok(r_c, w_s, w_t);
    assign w_sk_ok   = constraint_ok(sweep.sk_out, w_s, w_t);
    assign w_fail    = r_exists && !w_sk_ok;
    assign w_last    = (r_v == '1);

    assign sweep.sk_in      = r_v;
    assign sweep.busy       = r_busy;
    assign sweep.done       = r_done;
    assign sweep.pass       = r_pass;
    assign sweep.fail_cnt   = r_fail_cnt;
    assign sweep.vac_cnt    = r_vac_cnt;
    assign sweep.first_fail = r_first_fail;

    // Sweep FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_v          <= '0;
            r_c          <= '0;
            r_wcnt       <= '0;
            r_exists     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_cnt   <= '0;
            r_vac_cnt    <= '0;
            r_first_fail <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sweep.start) begin
                        r_v          <= '0;
                        r_c          <= '0;
                        r_exists     <= 1'b0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_fail_cnt   <= '0;
                        r_vac_cnt    <= '0;
                        r_first_fail <= '0;
                        r_state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_cand_ok) r_exists <= 1'b1;
                    r_c <= r_c + 1'b1;
                    if (r_c == '1) begin
                        r_wcnt  <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wcnt == WT_W'(SK_LAT)) r_state <= CHECK;
                    else                         r_wcnt  <= r_wcnt + 1'b1;
                end
                CHECK: begin
                    if (!r_exists) begin
                        r_vac_cnt <= r_vac_cnt + 1'b1;
                    end else if (!w_sk_ok) begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                        if (r_fail_cnt == '0) r_first_fail <= r_v;
                    end
`ifdef STOP_ON_FAIL_EN
                    if (w_last || w_fail) begin
`else
                    if (w_last) begin
`endif
                        r_state <= DONE;
                    end else begin
                        r_v      <= r_v + 1'b1;
                        r_c      <= '0;
                        r_exists <= 1'b0;
                        r_state  <= SCAN;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_pass  <= (r_fail_cnt == '0);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // w_fail only steers the early exit when STOP_ON_FAIL_EN is defined
    logic w_unused;
    assign w_unused = w_fail;
endmodule
